// File: rtl/qam16_demapper_if.sv
// Sample-in / symbol-out bundle for the 16-QAM demapper.
// err_mag exists only when QAM_DEMAP_ERR_EN is defined.
interface qam16_demapper_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic signed [DATA_W-1:0] I_data;
  logic signed [DATA_W-1:0] Q_data;
  logic                     data_valid_i;
  logic                     start;
  logic                     done_flag_i;
  logic [3:0]               symbol;
  logic                     data_valid_o;
  logic                     done_flag_o;
  logic [CNT_W-1:0]         sym_count;
  logic                     busy;
`ifdef QAM_DEMAP_ERR_EN
  logic [DATA_W:0]          err_mag;

  modport master (
    output I_data, Q_data, data_valid_i, start, done_flag_i,
    input  symbol, data_valid_o, done_flag_o, sym_count, busy, err_mag
  );
  modport slave (
    input  I_data, Q_data, data_valid_i, start, done_flag_i,
    output symbol, data_valid_o, done_flag_o, sym_count, busy, err_mag
  );
`else
  modport master (
    output I_data, Q_data, data_valid_i, start, done_flag_i,
    input  symbol, data_valid_o, done_flag_o, sym_count, busy
  );
  modport slave (
    input  I_data, Q_data, data_valid_i, start, done_flag_i,
    output symbol, data_valid_o, done_flag_o, sym_count, busy
  );
`endif
endinterface

// File: rtl/qam16_demapper.sv
// 16-QAM hard-decision demapper: 2-stage pipeline, start/done framed.
// Optional QAM_DEMAP_ERR_EN adds the err_mag distance-to-decision output.
module qam16_demapper #(
  parameter int DATA_W = 8,
  parameter int THR    = 41,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  qam16_demapper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic signed [DATA_W:0] THR_P = (DATA_W+1)'(THR);
  localparam logic signed [DATA_W:0] THR_N = -THR_P;

  state_t                   state_q, state_d;
  logic                     accept;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     busy_q;
  logic                     done_q;
  logic                     v1_q;
  logic signed [DATA_W-1:0] i_raw_q;
  logic signed [DATA_W-1:0] q_raw_q;
  logic                     dv_q;
  logic [3:0]               sym_q;
  logic [1:0]               i_bits, q_bits;

  function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] xe;
    xe = {x[DATA_W-1], x};
    if (xe <= THR_N)            return 2'b00;
    else if (x[DATA_W-1])       return 2'b10;
    else if (xe < THR_P)        return 2'b11;
    else                        return 2'b01;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        accept = bus.data_valid_i;
        if (accept && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (bus.done_flag_i) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_bits = slice(i_raw_q);
  assign q_bits = slice(q_raw_q);

`ifdef QAM_DEMAP_ERR_EN
  localparam logic signed [DATA_W+1:0] LVL_IN  = (DATA_W+2)'(20);
  localparam logic signed [DATA_W+1:0] LVL_OUT = (DATA_W+2)'(61);

  logic [DATA_W:0] err_q;

  function automatic logic [DATA_W:0] axis_err(input logic signed [DATA_W-1:0] x,
                                               input logic [1:0] b);
    logic signed [DATA_W+1:0] lvl;
    logic signed [DATA_W+1:0] d;
    case (b)
      2'b00:   lvl = -LVL_OUT;
      2'b10:   lvl = -LVL_IN;
      2'b11:   lvl = LVL_IN;
      default: lvl = LVL_OUT;
    endcase
    d = {{2{x[DATA_W-1]}}, x} - lvl;
    if (d[DATA_W+1]) d = -d;
    return d[DATA_W:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst)      err_q <= '0;
    else if (v1_q) err_q <= axis_err(i_raw_q, i_bits) + axis_err(q_raw_q, q_bits);
  end

  assign bus.err_mag = err_q;
`endif

  // Stage 1 holds the raw sample; stage 2 holds the decision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      i_raw_q <= '0;
      q_raw_q <= '0;
      dv_q    <= 1'b0;
      sym_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (state_d == RUN) || (state_d == FLUSH);
      done_q <= (state_q == DONE);
      v1_q   <= accept;
      if (accept) begin
        i_raw_q <= bus.I_data;
        q_raw_q <= bus.Q_data;
      end
      dv_q <= v1_q;
      if (v1_q) sym_q <= {i_bits, q_bits};
    end
  end

  assign bus.symbol       = sym_q;
  assign bus.data_valid_o = dv_q;
  assign bus.done_flag_o  = done_q;
  assign bus.sym_count    = cnt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_qam16_demapper.sv
// Directed bench for qam16_demapper; define QAM_DEMAP_ERR_EN to also check err_mag.
module tb_qam16_demapper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qam16_demapper_if #(.DATA_W(8), .CNT_W(16)) bus ();

  qam16_demapper #(.DATA_W(8), .THR(41), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int last_dv_cyc = 0;
  int last_done_cyc = 0;
  int done_edge = 0;
  logic [3:0] exp_sym_q[$];
  int         exp_err_q[$];
  logic [3:0] mon_sym;
  int         mon_err;
  logic [7:0] codes [4];
  logic [1:0] bits  [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops the expectation queue on each data_valid_o.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.data_valid_o === 1'b1) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        if (exp_sym_q.size() == 0) begin
          check_eq("unexpected_dv", 1, 0);
        end else begin
          mon_sym = exp_sym_q.pop_front();
          mon_err = exp_err_q.pop_front();
          $display("out symbol=%b expected=%b cyc=%0d", bus.symbol, mon_sym, cyc);
          check_eq("symbol", {28'd0, bus.symbol}, {28'd0, mon_sym});
`ifdef QAM_DEMAP_ERR_EN
          check_eq("err_mag", {23'd0, bus.err_mag}, mon_err);
`endif
        end
      end
      if (bus.done_flag_o === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic push(input logic [7:0] i, input logic [7:0] q, input logic [3:0] s,
                      input int e, input bit last, input bit expect_out);
    bus.I_data       = i;
    bus.Q_data       = q;
    bus.data_valid_i = 1'b1;
    bus.done_flag_i  = last;
    if (expect_out) begin
      exp_sym_q.push_back(s);
      exp_err_q.push_back(e);
    end
    tick();
    bus.data_valid_i = 1'b0;
    bus.done_flag_i  = 1'b0;
    if (last) done_edge = cyc;
  endtask

  task automatic send_done();
    bus.done_flag_i = 1'b1;
    tick();
    bus.done_flag_i = 1'b0;
    done_edge = cyc;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_cnt != d0) break;
    end
    check_eq({tag, "_done_seen"}, done_cnt - d0, 1);
    if (done_cnt != d0) check_eq({tag, "_done_lat"}, last_done_cyc - done_edge, 2);
    tick();
    tick();
    check_eq({tag, "_done_once"}, done_cnt - d0, 1);
    check_eq({tag, "_pending"}, exp_sym_q.size(), 0);
    check_eq({tag, "_busy_idle"}, {31'd0, bus.busy}, 0);
  endtask

  function automatic logic [7:0] map_code(input logic [1:0] b);
    case (b)
      2'b00:   return 8'hC3;
      2'b10:   return 8'hEC;
      2'b11:   return 8'h14;
      default: return 8'h3D;
    endcase
  endfunction

  initial begin
    int dv0;
    int d0;
    logic [3:0] rs;
    codes[0] = 8'hC3; bits[0] = 2'b00;
    codes[1] = 8'hEC; bits[1] = 2'b10;
    codes[2] = 8'h14; bits[2] = 2'b11;
    codes[3] = 8'h3D; bits[3] = 2'b01;

    rst = 1'b0;
    bus.I_data = '0; bus.Q_data = '0;
    bus.data_valid_i = 1'b0; bus.start = 1'b0; bus.done_flag_i = 1'b0;
    repeat (3) tick();
    check_eq("rst_symbol", {28'd0, bus.symbol}, 0);
    check_eq("rst_dv", {31'd0, bus.data_valid_o}, 0);
    check_eq("rst_done", {31'd0, bus.done_flag_o}, 0);
    check_eq("rst_count", {16'd0, bus.sym_count}, 0);
    check_eq("rst_busy", {31'd0, bus.busy}, 0);
`ifdef QAM_DEMAP_ERR_EN
    check_eq("rst_err", {23'd0, bus.err_mag}, 0);
`endif
    rst = 1'b1;
    tick();

    // Exact constellation points
    dv0 = dv_cnt;
    do_start();
    check_eq("busy_run", {31'd0, bus.busy}, 1);
    for (int ii = 0; ii < 4; ii++)
      for (int qq = 0; qq < 4; qq++)
        push(codes[ii], codes[qq], {bits[ii], bits[qq]}, 0, 1'b0, 1'b1);
    send_done();
    wait_done("exact");
    check_eq("exact_count", {16'd0, bus.sym_count}, 16);
    check_eq("exact_dv_pulses", dv_cnt - dv0, 16);

    // Threshold edges on I with Q=0
    do_start();
    push(8'hD7, 8'h00, 4'b0011, 40, 1'b0, 1'b1);  // -41
    push(8'hD8, 8'h00, 4'b1011, 40, 1'b0, 1'b1);  // -40
    push(8'hFF, 8'h00, 4'b1011, 39, 1'b0, 1'b1);  // -1
    push(8'h00, 8'h00, 4'b1111, 40, 1'b0, 1'b1);  // 0
    push(8'h28, 8'h00, 4'b1111, 40, 1'b0, 1'b1);  // 40
    push(8'h29, 8'h00, 4'b0111, 40, 1'b0, 1'b1);  // 41
    send_done();
    wait_done("thr");
    check_eq("thr_count", {16'd0, bus.sym_count}, 6);

    // Framing: samples outside a frame are ignored; dv with done is the last sample
    push(8'hC3, 8'hC3, 4'b0000, 0, 1'b0, 1'b0);
    push(8'h3D, 8'h3D, 4'b0101, 0, 1'b0, 1'b0);
    tick();
    check_eq("idle_count_hold", {16'd0, bus.sym_count}, 6);
    do_start();
    push(8'hC3, 8'h3D, 4'b0001, 0, 1'b0, 1'b1);
    push(8'h14, 8'hEC, 4'b1110, 0, 1'b1, 1'b1);
    wait_done("last");
    check_eq("last_dv_to_done", last_done_cyc - last_dv_cyc, 1);
    check_eq("last_count", {16'd0, bus.sym_count}, 2);
    push(8'hEC, 8'hEC, 4'b1010, 0, 1'b0, 1'b0);
    tick();
    check_eq("post_done_count", {16'd0, bus.sym_count}, 2);

    // start together with done in IDLE: done ignored
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.done_flag_i = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.done_flag_i = 1'b0;
    repeat (4) tick();
    check_eq("startdone_busy", {31'd0, bus.busy}, 1);
    check_eq("startdone_no_done", done_cnt - d0, 0);
    push(8'h1E, 8'hC0, 4'b1100, 13, 1'b0, 1'b1);  // I=30, Q=-64
    send_done();
    wait_done("errm");
`ifdef QAM_DEMAP_ERR_EN
    check_eq("err_hold", {23'd0, bus.err_mag}, 13);
`endif

    // Loopback through the bench mapper table
    do_start();
    for (int n = 0; n < 12; n++) begin
      rs = 4'($urandom_range(0, 15));
      push(map_code(rs[3:2]), map_code(rs[1:0]), rs, 0, 1'b0, 1'b1);
    end
    send_done();
    wait_done("loop");
    check_eq("loop_count", {16'd0, bus.sym_count}, 12);

    // Reset mid-frame: the third sample is still in flight and must vanish
    do_start();
    push(8'hC3, 8'hEC, 4'b0010, 0, 1'b0, 1'b1);
    push(8'h14, 8'h3D, 4'b1101, 0, 1'b0, 1'b1);
    push(8'h3D, 8'h14, 4'b0111, 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_eq("mid_symbol", {28'd0, bus.symbol}, 0);
    check_eq("mid_dv", {31'd0, bus.data_valid_o}, 0);
    check_eq("mid_count", {16'd0, bus.sym_count}, 0);
    check_eq("mid_busy", {31'd0, bus.busy}, 0);
    rst = 1'b1;
    d0 = done_cnt;
    dv0 = dv_cnt;
    repeat (5) tick();
    check_eq("mid_no_done", done_cnt - d0, 0);
    check_eq("mid_no_dv", dv_cnt - dv0, 0);
    check_eq("mid_pending", exp_sym_q.size(), 0);
    do_start();
    push(8'hEC, 8'hC3, 4'b1000, 0, 1'b0, 1'b1);
    push(8'h3D, 8'h14, 4'b0111, 0, 1'b0, 1'b1);
    send_done();
    wait_done("after_rst");
    check_eq("after_rst_count", {16'd0, bus.sym_count}, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qam16_demapper.md
Name: qam16_demapper

Overview:
- Receive-side counterpart of the 16-QAM symbol mapper.
- Accepts 8-bit signed I/Q samples framed by start/done, hard-slices each axis to the nearest constellation level and emits the 4-bit symbol {I bits, Q bits}.
- Sits at the demodulator output, feeding the symbol-to-bit stage.
- Uses the same start / data_valid / done framing as the mapper, so the two can run back to back in loopback.

Parameters:
- DATA_W, 8: I/Q sample width, two's complement.
- THR, 41: outer decision threshold magnitude; constellation levels are ±20 (±1/sqrt(10)) and ±61 (±3/sqrt(10)).
- CNT_W, 16: width of the accepted-symbol counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active low.
- I_data  in  DATA_W  in-phase sample, signed.
- Q_data  in  DATA_W  quadrature sample, signed.
- data_valid_i  in  1  sample valid, one sample per high cycle.
- start  in  1  one-cycle frame start pulse.
- done_flag_i  in  1  one-cycle end-of-frame pulse.
- symbol  out  4  decoded symbol {I[1:0], Q[1:0]}.
- data_valid_o  out  1  symbol valid.
- done_flag_o  out  1  one-cycle end-of-frame pulse.
- sym_count  out  CNT_W  symbols decoded in the current frame.
- busy  out  1  high in RUN and FLUSH.

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE; symbol=0, data_valid_o=0, done_flag_o=0, sym_count=0, busy=0; pipeline valids cleared. Reset mid-frame discards all in-flight samples; no done_flag_o is produced.
- Per-axis slicer, x signed:
  - x <= -THR → 2'b00
  - -THR < x < 0 → 2'b10
  - 0 <= x < THR → 2'b11
  - x >= THR → 2'b01
  - Exact inverse of the mapper codes: 0xC3→00, 0xEC→10, 0x3D→01, 0x14→11. Full range -128..127 is covered; no saturation needed.
- Pipeline: 2 stages.
  - A sample accepted at edge N is registered raw at N.
  - The sliced symbol and data_valid_o are registered at N+1 and visible for one cycle.
  - Output order equals input order; no back-pressure; every accepted sample yields exactly one output.
- FSM:
  - IDLE: start=1 → RUN and clear sym_count. data_valid_i and done_flag_i are ignored in IDLE.
  - RUN: data_valid_i=1 → accept sample, sym_count+1 (saturates at all-ones). done_flag_i=1 → FLUSH. If data_valid_i and done_flag_i are high in the same cycle, the sample is accepted as the last one. start in RUN is ignored.
  - FLUSH: data_valid_i ignored. Wait 1 cycle, then DONE.
  - DONE: done_flag_o=1 for exactly one cycle, then IDLE.
- Done timing: done_flag_i at edge N → done_flag_o registered at N+2. This is one cycle after the last data_valid_o, and always within 5 cycles of done_flag_i.
- start and done_flag_i in the same cycle while in IDLE: enter RUN, ignore done.
- sym_count holds its final value in IDLE until the next start.
- busy is a registered decode of state ∈ {RUN, FLUSH}.

Optional Feature:
- Macro: QAM_DEMAP_ERR_EN.
- When defined, adds output err_mag [DATA_W:0], registered alongside data_valid_o: |I - level_I| + |Q - level_Q|, where level is the decided constellation value (±20/±61), computed at DATA_W+1 bits, unsigned, no overflow possible. err_mag resets to 0 and holds its value when data_valid_o=0.
- When undefined, the port and its logic are absent and the rest of the block is bit-identical.

Test Plan:
- Exact points: start, then the 16 pairs from {0xC3,0xEC,0x14,0x3D}², then done → symbols match the inverse map (e.g. I=0xC3,Q=0x3D → 4'b0001); 16 data_valid_o pulses; sym_count=16; done_flag_o 2 edges after done_flag_i.
- Thresholds: I=-41,-40,-1,0,40,41 with Q=0 → I bits 00,10,10,11,11,01; Q bits 11 throughout.
- Loopback: 12 random symbols → mapper → demapper → identical symbols in order; done_flag_o within 5 cycles; err_mag=0 when QAM_DEMAP_ERR_EN is defined.
- Framing: data_valid_i before start and after done is ignored (sym_count unchanged); data_valid_i together with done_flag_i → that sample is output, then done_flag_o on the next cycle.
- Reset mid-frame: after 3 samples, rst=0 for one edge → all outputs 0, no data_valid_o or done_flag_o afterwards; a new start frame works normally.
- Error metric (macro on): I=0x1E(30), Q=0xC0(-64) → symbol 4'b1100, err_mag=10+3=13.
